// File: rtl/board_reset_ctrl.sv
// Board reset/status controller: synchronises PLL lock and the user button,
// sequences the core reset and drives a heartbeat/activity status LED.
module board_reset_ctrl #(
    parameter int unsigned SyncStages          = 2,
    parameter int unsigned ResetHoldCycles     = 1024,
    parameter int unsigned DebounceCycles      = 65536,
    parameter bit          BtnActiveLow        = 1'b1,
    parameter int unsigned HeartbeatHalf       = 24000000,
    parameter int unsigned ActivityPulseCycles = 2400000,
    parameter int unsigned NumActivity         = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pll_lock_i,
    input  logic                   reset_unsafe_i,
    input  logic [NumActivity-1:0] activity_i,
    output logic                   reset_o,
    output logic                   led_n_o,
    output logic                   ready_o
);

    localparam int unsigned DbW    = $clog2(DebounceCycles + 1);
    localparam int unsigned HoldW  = $clog2(ResetHoldCycles + 1);
    localparam int unsigned HbW    = $clog2(HeartbeatHalf + 1);
    localparam int unsigned BlinkW = $clog2(ActivityPulseCycles + 1);

    localparam logic [DbW-1:0]    DbLast    = DbW'(DebounceCycles - 1);
    localparam logic [HoldW-1:0]  HoldLast  = HoldW'(ResetHoldCycles - 1);
    localparam logic [HbW-1:0]    HbLast    = HbW'(HeartbeatHalf - 1);
    localparam logic [BlinkW-1:0] BlinkLoad = BlinkW'(ActivityPulseCycles);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RUN
    } state_e;

    logic [SyncStages-1:0]  lock_sync_q, btn_sync_q;
    logic                   lock_s, btn_s;
    logic                   btn_db_q, btn_db_d;
    logic [DbW-1:0]         db_cnt_q, db_cnt_d;
    state_e                 state_q, state_d;
    logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [HbW-1:0]         hb_cnt_q, hb_cnt_d;
    logic                   phase_q, phase_d;
    logic [BlinkW-1:0]      blink_cnt_q, blink_cnt_d;
    logic [NumActivity-1:0] act_prev_q;
    logic                   act_rise;

    assign lock_s   = lock_sync_q[SyncStages-1];
    assign btn_s    = BtnActiveLow ? ~btn_sync_q[SyncStages-1] : btn_sync_q[SyncStages-1];
    assign act_rise = |(activity_i & ~act_prev_q);

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DbLast) begin
                btn_db_d = btn_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s && !btn_db_q) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (!btn_db_q) begin
                    if (hold_cnt_q == HoldLast) state_d = RUN;
                    else                        hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s)       state_d = WAIT_LOCK;
                else if (btn_db_q) state_d = HOLD;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // LED timers only run while staying in RUN, so they start clean on entry
    // and are cleared on the very edge that leaves RUN.
    always_comb begin
        hb_cnt_d    = '0;
        phase_d     = 1'b0;
        blink_cnt_d = '0;
        if (state_q == RUN && state_d == RUN) begin
            if (hb_cnt_q == HbLast) begin
                phase_d = ~phase_q;
            end else begin
                hb_cnt_d = hb_cnt_q + 1'b1;
                phase_d  = phase_q;
            end
            if (act_rise)                blink_cnt_d = BlinkLoad;
            else if (blink_cnt_q != '0) blink_cnt_d = blink_cnt_q - 1'b1;
        end
    end

    always_comb begin
        reset_o = (state_q != RUN);
        ready_o = (state_q == RUN);
        led_n_o = 1'b1;
        unique case (state_q)
            WAIT_LOCK: led_n_o = 1'b1;
            HOLD:      led_n_o = 1'b0;
            RUN:       led_n_o = (blink_cnt_q != '0) ? 1'b1 : phase_q;
            default:   led_n_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync_q <= '0;
            btn_sync_q  <= {SyncStages{BtnActiveLow}};
            btn_db_q    <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= WAIT_LOCK;
            hold_cnt_q  <= '0;
            hb_cnt_q    <= '0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
            act_prev_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_lock_i};
            btn_sync_q  <= {btn_sync_q[SyncStages-2:0], reset_unsafe_i};
            btn_db_q    <= btn_db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            hb_cnt_q    <= hb_cnt_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            act_prev_q  <= activity_i;
        end
    end

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Directed bench for board_reset_ctrl with small timing parameters.
module tb_board_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       btn_raw;
    logic [1:0] act;
    logic       rst_out, led_n, ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_reset_ctrl #(
        .SyncStages         (2),
        .ResetHoldCycles    (8),
        .DebounceCycles     (4),
        .BtnActiveLow       (1'b1),
        .HeartbeatHalf      (16),
        .ActivityPulseCycles(5),
        .NumActivity        (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pll_lock_i    (pll_lock),
        .reset_unsafe_i(btn_raw),
        .activity_i    (act),
        .reset_o       (rst_out),
        .led_n_o       (led_n),
        .ready_o       (ready)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Each tick passes one rising edge; sampling happens on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; pll_lock = 1'b0; btn_raw = 1'b1; act = 2'b00;
        #1;
        check("por_reset", rst_out, 1'b1);
        check("por_ready", ready, 1'b0);
        check("por_led", led_n, 1'b1);
        tick(2);
        check("rst_held_reset", rst_out, 1'b1);

        // Bring-up: lock rises before edge 0
        rst_n = 1'b1; pll_lock = 1'b1;
        tick(1);
        check("bu_e0_reset", rst_out, 1'b1);
        check("bu_e0_led", led_n, 1'b1);
        tick(1);
        check("bu_e1_led", led_n, 1'b1);
        tick(1);
        check("bu_e2_led", led_n, 1'b0);
        check("bu_e2_reset", rst_out, 1'b1);
        tick(7);
        check("bu_e9_reset", rst_out, 1'b1);
        check("bu_e9_ready", ready, 1'b0);
        tick(1);
        check("bu_e10_reset", rst_out, 1'b0);
        check("bu_e10_ready", ready, 1'b1);

        // Heartbeat from edge 10: 16 on, 16 off, 16 on
        for (int i = 0; i < 48; i++) begin
            check("heartbeat", led_n, ((i / 16) % 2) == 1);
            tick(1);
        end

        // Activity retrigger on channel 1 at edges 76 and 79 (phase low 74..89)
        tick(17);
        act = 2'b10;
        tick(1);
        check("act_e76", led_n, 1'b1);
        act = 2'b00;
        tick(1);
        check("act_e77", led_n, 1'b1);
        tick(1);
        check("act_e78", led_n, 1'b1);
        act = 2'b10;
        tick(1);
        check("act_e79", led_n, 1'b1);
        act = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("act_retrig", led_n, 1'b1);
        end
        tick(1);
        check("act_end_e84", led_n, 1'b0);

        // Blink at edge 88 straddles the heartbeat toggle at edge 90
        tick(3);
        act = 2'b01;
        tick(1);
        check("blink2_e88", led_n, 1'b1);
        act = 2'b00;
        tick(4);
        check("blink2_e92", led_n, 1'b1);
        tick(1);
        check("phase_toggled_e93", led_n, 1'b1);
        tick(12);
        check("phase_e105", led_n, 1'b1);
        tick(1);
        check("phase_e106", led_n, 1'b0);

        // Short bounces never reach the debounce threshold
        for (int p = 0; p < 3; p++) begin
            btn_raw = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                check("bounce_low", rst_out, 1'b0);
            end
            btn_raw = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                check("bounce_gap", rst_out, 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("bounce_after", rst_out, 1'b0);
        end

        // Stable press then release
        btn_raw = 1'b0;
        tick(6);
        check("press_e5_reset", rst_out, 1'b0);
        tick(1);
        check("press_e6_reset", rst_out, 1'b1);
        check("press_e6_ready", ready, 1'b0);
        check("press_e6_led", led_n, 1'b0);
        tick(3);
        btn_raw = 1'b1;
        tick(13);
        check("release_r12_reset", rst_out, 1'b1);
        tick(1);
        check("release_r13_reset", rst_out, 1'b0);
        check("release_r13_ready", ready, 1'b1);

        // Lock drop in RUN, relock, drop again in HOLD, relock
        pll_lock = 1'b0;
        tick(2);
        check("drop_run_f1", rst_out, 1'b0);
        tick(1);
        check("drop_run_f2_reset", rst_out, 1'b1);
        check("drop_run_f2_led", led_n, 1'b1);
        pll_lock = 1'b1;
        tick(2);
        check("relock_g1_led", led_n, 1'b1);
        tick(1);
        check("relock_g2_led", led_n, 1'b0);
        tick(2);
        pll_lock = 1'b0;
        tick(2);
        check("drop_hold_h1_led", led_n, 1'b0);
        check("drop_hold_h1_reset", rst_out, 1'b1);
        tick(1);
        check("drop_hold_h2_led", led_n, 1'b1);
        pll_lock = 1'b1;
        tick(3);
        check("relock2_k2_led", led_n, 1'b0);
        tick(7);
        check("relock2_k9_reset", rst_out, 1'b1);
        tick(1);
        check("relock2_k10_reset", rst_out, 1'b0);

        // Simultaneous lock loss and press: must land in WAIT_LOCK, not HOLD
        pll_lock = 1'b0; btn_raw = 1'b0;
        tick(2);
        check("simul_1_reset", rst_out, 1'b0);
        tick(1);
        check("simul_2_reset", rst_out, 1'b1);
        check("simul_2_led", led_n, 1'b1);
        tick(5);
        check("simul_7_led", led_n, 1'b1);
        pll_lock = 1'b1; btn_raw = 1'b1;
        tick(6);
        check("recover_m5_led", led_n, 1'b1);
        tick(1);
        check("recover_m6_led", led_n, 1'b0);
        tick(7);
        check("recover_m13_reset", rst_out, 1'b1);
        tick(1);
        check("recover_m14_reset", rst_out, 1'b0);

        // Async reset mid-blink, between clock edges
        act = 2'b01;
        tick(1);
        act = 2'b00;
        tick(1);
        check("pre_arst_led", led_n, 1'b1);
        check("pre_arst_ready", ready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_reset", rst_out, 1'b1);
        check("arst_ready", ready, 1'b0);
        check("arst_led", led_n, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
